// File: rtl/spi_qspi_ctrl_if.sv
// Register request/response channel from the AXI front-end, and the SPI pad bundle.
interface qspi_bus_if;
  logic       req_vld, req_rdy, req_read, rsp_vld, rsp_rdy;
  logic [2:0] req_addr;
  logic [7:0] req_dat, rsp_dat;
  modport master (output req_vld, req_addr, req_read, req_dat, rsp_rdy,
                  input  req_rdy, rsp_vld, rsp_dat);
  modport slave  (input  req_vld, req_addr, req_read, req_dat, rsp_rdy,
                  output req_rdy, rsp_vld, rsp_dat);
endinterface

interface spi_pad_if;
  logic       sck_o, sdo_en, sdo_o, sdo_i, sdi_en, sdi_o, sdi_i;
  logic [3:0] csn_en, csn_o, csn_i;
  modport master (output sck_o, csn_en, csn_o, sdo_en, sdo_o, sdi_en, sdi_o,
                  input  csn_i, sdo_i, sdi_i);
  modport pad    (input  sck_o, csn_en, csn_o, sdo_en, sdo_o, sdi_en, sdi_o,
                  output csn_i, sdo_i, sdi_i);
endinterface

// File: rtl/spi_qspi_ctrl.sv
// Byte-wide register-mapped SPI master: CTRL/STATUS/DATA/DIV/CS/CSIN registers,
// TX/RX byte FIFOs and a shift engine supporting all CPOL/CPHA modes.
module spi_qspi_ctrl #(
  parameter int          FIFO_DP = 4,
  parameter logic [7:0]  DIV_RST = 8'h03
) (
  input  logic       aclk,
  input  logic       aresetn,
  qspi_bus_if.slave  qspi_if,
  spi_pad_if.master  spi_if,
  output logic       qspi_busy,
  output logic       qspi_irq
);
  localparam int AW = $clog2(FIFO_DP);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DP);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} st_e;

  logic [7:0] ctrl_q, div_q, cs_q, rsp_dat_q, rdata;
  logic       rsp_vld_q, done_q, wcol_q;
  logic       acc, wr, wr_ctrl, wr_stat, wr_data, rd_data, abort;
  logic       en, cpol, cpha;

  logic [7:0]    tx_mem [FIFO_DP];
  logic [7:0]    rx_mem [FIFO_DP];
  logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [AW:0]   tx_cnt_q, rx_cnt_q;
  logic          tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;

  st_e        state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d, sr_q, sr_d, rxs_q, rxs_d, div_l_q, div_l_d, rx_nxt;
  logic [3:0] edg_q, edg_d;
  logic       sck_q, sck_d, sdo_q, sdo_d, cpha_l_q, cpha_l_d;
  logic       tick, edge_odd, samp, shft, start, byte_done;
  logic       unused_sdo;

  assign en   = ctrl_q[6];
  assign cpol = ctrl_q[3];
  assign cpha = ctrl_q[2];

  assign acc     = qspi_if.req_vld & ~rsp_vld_q;
  assign wr      = acc & ~qspi_if.req_read;
  assign wr_ctrl = wr & (qspi_if.req_addr == 3'd0);
  assign wr_stat = wr & (qspi_if.req_addr == 3'd1);
  assign wr_data = wr & (qspi_if.req_addr == 3'd2);
  assign rd_data = acc & qspi_if.req_read & (qspi_if.req_addr == 3'd2);
  // Only an EN 1->0 write aborts and flushes, so bytes can be queued while disabled.
  assign abort   = wr_ctrl & en & ~qspi_if.req_dat[6];

  assign tx_full  = (tx_cnt_q == FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_push  = wr_data & ~tx_full;
  assign tx_pop   = start;
  assign rx_push  = byte_done;
  assign rx_pop   = rd_data & ~rx_empty;

  assign qspi_busy = (state_q != IDLE) | (~tx_empty & en);
  assign qspi_irq  = done_q & ctrl_q[7];

  assign qspi_if.req_rdy = ~rsp_vld_q;
  assign qspi_if.rsp_vld = rsp_vld_q;
  assign qspi_if.rsp_dat = rsp_dat_q;

  assign spi_if.sck_o  = (state_q == SHIFT) ? sck_q : cpol;
  assign spi_if.sdo_o  = sdo_q;
  assign spi_if.sdo_en = en;
  assign spi_if.csn_en = cs_q[7:4];
  assign spi_if.csn_o  = cs_q[3:0];
  assign spi_if.sdi_en = 1'b0;
  assign spi_if.sdi_o  = 1'b0;
  assign unused_sdo    = spi_if.sdo_i;

  // Read data mux for the addressed register.
  always_comb begin
    rdata = 8'h00;
    case (qspi_if.req_addr)
      3'd0: rdata = ctrl_q;
      3'd1: rdata = {done_q, wcol_q, 1'b0, qspi_busy, tx_full, tx_empty, rx_full, rx_empty};
      3'd2: rdata = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
      3'd3: rdata = div_q;
      3'd4: rdata = cs_q;
      3'd5: rdata = {4'b0, spi_if.csn_i};
      default: rdata = 8'h00;
    endcase
  end

  // Register file, status flags and the single-outstanding response slot.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_q <= 8'h00; div_q <= DIV_RST; cs_q <= 8'h0F;
      done_q <= 1'b0; wcol_q <= 1'b0;
      rsp_vld_q <= 1'b0; rsp_dat_q <= 8'h00;
    end else begin
      if (wr_ctrl) ctrl_q <= qspi_if.req_dat & 8'hCC;
      if (wr & (qspi_if.req_addr == 3'd3)) div_q <= qspi_if.req_dat;
      if (wr & (qspi_if.req_addr == 3'd4)) cs_q  <= qspi_if.req_dat;
      // Set beats W1C when both land in the same cycle.
      done_q <= (done_q & ~(wr_stat & qspi_if.req_dat[7])) | byte_done;
      wcol_q <= (wcol_q & ~(wr_stat & qspi_if.req_dat[6])) | (wr_data & tx_full);
      if (acc) begin
        rsp_vld_q <= 1'b1;
        rsp_dat_q <= qspi_if.req_read ? rdata : 8'h00;
      end else if (qspi_if.rsp_rdy) begin
        rsp_vld_q <= 1'b0;
      end
    end
  end

  // FIFO storage (contents need no reset; pointers and counts do).
  always_ff @(posedge aclk) begin
    if (tx_push) tx_mem[tx_wp_q] <= qspi_if.req_dat;
    if (rx_push) rx_mem[rx_wp_q] <= rx_nxt;
  end

  // FIFO pointers and occupancy; disable flushes both queues.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
    end else if (abort) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
      rx_cnt_q <= rx_cnt_q + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
    end
  end

  // Shift engine state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE; hcnt_q <= 8'h00; edg_q <= 4'h0; sr_q <= 8'h00; rxs_q <= 8'h00;
      sck_q <= 1'b0; sdo_q <= 1'b0; cpha_l_q <= 1'b0; div_l_q <= 8'h00;
    end else begin
      state_q <= state_d; hcnt_q <= hcnt_d; edg_q <= edg_d; sr_q <= sr_d; rxs_q <= rxs_d;
      sck_q <= sck_d; sdo_q <= sdo_d; cpha_l_q <= cpha_l_d; div_l_q <= div_l_d;
    end
  end

  // Shift engine next state: mode and divider are latched per byte.
  always_comb begin
    state_d = state_q; hcnt_d = hcnt_q; edg_d = edg_q; sr_d = sr_q; rxs_d = rxs_q;
    sck_d = sck_q; sdo_d = sdo_q; cpha_l_d = cpha_l_q; div_l_d = div_l_q;
    start = 1'b0; byte_done = 1'b0;
    tick     = (hcnt_q == div_l_q);
    edge_odd = ~edg_q[0];  // the upcoming edge is number edg_q+1
    samp     = tick & (cpha_l_q ? ~edge_odd : edge_odd);
    shft     = tick & (cpha_l_q ? edge_odd : (~edge_odd & (edg_q != 4'd15)));
    rx_nxt   = samp ? {rxs_q[6:0], spi_if.sdi_i} : rxs_q;
    case (state_q)
      IDLE: if (en & ~tx_empty & ~rx_full & ~abort) begin
        start = 1'b1; state_d = SHIFT; hcnt_d = 8'h00; edg_d = 4'h0; rxs_d = 8'h00;
        sck_d = cpol; cpha_l_d = cpha; div_l_d = div_q;
        sr_d  = cpha ? tx_mem[tx_rp_q] : {tx_mem[tx_rp_q][6:0], 1'b0};
        if (!cpha) sdo_d = tx_mem[tx_rp_q][7];
      end
      SHIFT: if (abort) begin
        state_d = IDLE;
      end else begin
        hcnt_d = tick ? 8'h00 : hcnt_q + 8'd1;
        if (tick) begin
          sck_d = ~sck_q; edg_d = edg_q + 4'd1; rxs_d = rx_nxt;
          if (shft) begin sdo_d = sr_q[7]; sr_d = {sr_q[6:0], 1'b0}; end
          if (edg_q == 4'd15) begin byte_done = 1'b1; state_d = GAP; end
        end
      end
      GAP: if (abort || tick) begin
        state_d = IDLE;
      end else begin
        hcnt_d = hcnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
